// File: rtl/gp_readback_pkg.sv
// Shared types and default sizes for the GP register readback sequencer.
package gp_readback_pkg;
  localparam int DEFAULT_NUM_REGS = 16;
  localparam int DEFAULT_DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD,
    DONE
  } state_t;
endpackage

// File: rtl/gp_readback_sequencer.sv
// Steps the GP register-file mux over a window, captures each settled bus value and streams it out.
// Define READBACK_CHECKSUM_EN to build the running checksum of accepted words; otherwise it reads 0.
module gp_readback_sequencer
  import gp_readback_pkg::*;
#(
  parameter int NUM_REGS      = DEFAULT_NUM_REGS,
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int SEL_W         = $clog2(NUM_REGS),
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [SEL_W-1:0]  first_sel,
  input  logic [SEL_W:0]    count,
  output logic [SEL_W-1:0]  gp_register_select,
  input  logic [DATA_W-1:0] BusMuxOut,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int CTR_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CTR_W-1:0] SETTLE_RELOAD = CTR_W'(SETTLE_CYCLES);
  localparam logic [CTR_W-1:0] CTR_ONE       = CTR_W'(1);
  localparam logic [SEL_W:0]   REM_ONE       = (SEL_W + 1)'(1);
  localparam logic [SEL_W-1:0] SEL_ONE       = SEL_W'(1);

  state_t              state_reg, state_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [SEL_W:0]      remaining_reg, remaining_next;
  logic [CTR_W-1:0]    settle_ctr_reg, settle_ctr_next;
  logic                out_valid_reg, out_valid_next;
  logic [SEL_W-1:0]    out_index_reg, out_index_next;
  logic [DATA_W-1:0]   out_data_reg, out_data_next;
`ifdef READBACK_CHECKSUM_EN
  logic [DATA_W-1:0]   checksum_reg, checksum_next;
`endif

  always_comb begin
    state_next      = state_reg;
    sel_next        = sel_reg;
    remaining_next  = remaining_reg;
    settle_ctr_next = settle_ctr_reg;
    out_valid_next  = out_valid_reg;
    out_index_next  = out_index_reg;
    out_data_next   = out_data_reg;
`ifdef READBACK_CHECKSUM_EN
    checksum_next   = checksum_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            state_next = DONE;
          end else begin
            sel_next        = first_sel;
            remaining_next  = count;
            settle_ctr_next = SETTLE_RELOAD;
            state_next      = SETTLE;
`ifdef READBACK_CHECKSUM_EN
            checksum_next   = '0;
`endif
          end
        end
      end
      SETTLE: begin
        if (settle_ctr_reg != '0) begin
          settle_ctr_next = settle_ctr_reg - CTR_ONE;
        end else begin
          out_data_next  = BusMuxOut;
          out_index_next = sel_reg;
          out_valid_next = 1'b1;
          state_next     = HOLD;
        end
      end
      HOLD: begin
        if (out_valid_reg && out_ready) begin
          out_valid_next = 1'b0;
          remaining_next = remaining_reg - REM_ONE;
`ifdef READBACK_CHECKSUM_EN
          checksum_next  = checksum_reg + out_data_reg;
`endif
          if (remaining_reg == REM_ONE) begin
            state_next = DONE;
          end else begin
            // Power-of-two register count, so natural overflow is the modulo wrap.
            sel_next        = sel_reg + SEL_ONE;
            settle_ctr_next = SETTLE_RELOAD;
            state_next      = SETTLE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_reg      <= IDLE;
      sel_reg        <= '0;
      remaining_reg  <= '0;
      settle_ctr_reg <= '0;
      out_valid_reg  <= 1'b0;
      out_index_reg  <= '0;
      out_data_reg   <= '0;
`ifdef READBACK_CHECKSUM_EN
      checksum_reg   <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      remaining_reg  <= remaining_next;
      settle_ctr_reg <= settle_ctr_next;
      out_valid_reg  <= out_valid_next;
      out_index_reg  <= out_index_next;
      out_data_reg   <= out_data_next;
`ifdef READBACK_CHECKSUM_EN
      checksum_reg   <= checksum_next;
`endif
    end
  end

  assign gp_register_select = sel_reg;
  assign out_valid          = out_valid_reg;
  assign out_index          = out_index_reg;
  assign out_data           = out_data_reg;
  assign busy               = (state_reg != IDLE);
  assign done               = (state_reg == DONE);
`ifdef READBACK_CHECKSUM_EN
  assign checksum           = checksum_reg;
`else
  assign checksum           = '0;
`endif

endmodule

// File: tb/tb_gp_readback_sequencer.sv
// Self-checking bench: transaction model of the readback window compared every cycle, plus literal pins.
module tb_gp_readback_sequencer;
  localparam int NR = 16;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int S  = 1;
`ifdef READBACK_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          clear = 1'b0, start = 1'b0, out_ready = 1'b1, start0 = 1'b0, ready0 = 1'b1;
  logic [SW-1:0] first_sel = '0;
  logic [SW:0]   count = '0;
  logic [SW-1:0] sel, out_index, sel0, idx0;
  logic [DW-1:0] bus, out_data, checksum, bus0, data0, csum0;
  logic          out_valid, busy, done, v0, busy0, done0;

  // Register file model: R[i] = i * 0x11, combinational mux.
  function automatic logic [DW-1:0] reg_val(input int i);
    return DW'(i * 32'h11);
  endfunction
  assign bus  = reg_val(int'(sel));
  assign bus0 = reg_val(int'(sel0));

  gp_readback_sequencer #(.NUM_REGS(NR), .DATA_W(DW), .SEL_W(SW), .SETTLE_CYCLES(S)) dut (
    .clock(clock), .clear(clear), .start(start), .first_sel(first_sel), .count(count),
    .gp_register_select(sel), .BusMuxOut(bus), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_data(out_data), .busy(busy), .done(done), .checksum(checksum));

  gp_readback_sequencer #(.NUM_REGS(NR), .DATA_W(DW), .SEL_W(SW), .SETTLE_CYCLES(0)) dut0 (
    .clock(clock), .clear(clear), .start(start0), .first_sel(first_sel), .count(count),
    .gp_register_select(sel0), .BusMuxOut(bus0), .out_valid(v0), .out_ready(ready0),
    .out_index(idx0), .out_data(data0), .busy(busy0), .done(done0), .checksum(csum0));

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: queue of indices still to deliver plus the visible output state.
  int            m_q[$];
  bit            m_busy = 0, m_valid = 0, m_done = 0, chk_en = 0;
  logic [SW-1:0] m_sel = '0, m_idx = '0;
  logic [DW-1:0] m_data = '0, m_csum = '0;
  int            m_wait = 0;

  int            acc_idx[$], acc_cyc[$];
  logic [DW-1:0] acc_data[$];
  int            done_cnt = 0;
  bit            p_valid = 0, p_ready = 0, p_clear = 0;
  logic [SW-1:0] p_idx;
  logic [DW-1:0] p_data;

  always @(negedge clock) begin
    if (chk_en) begin
      chk("out_valid", DW'(out_valid), DW'(m_valid));
      chk("busy", DW'(busy), DW'(m_busy));
      chk("done", DW'(done), DW'(m_done));
      chk("select", DW'(sel), DW'(m_sel));
      chk("checksum", checksum, CSUM_EN ? m_csum : '0);
      if (m_valid) begin
        chk("out_index", DW'(out_index), DW'(m_idx));
        chk("out_data", out_data, m_data);
      end
      if (p_valid && !p_ready && p_clear && clear) begin
        chk("hold_data_stable", out_data, p_data);
        chk("hold_index_stable", DW'(out_index), DW'(p_idx));
      end
      if (done) done_cnt++;
      if (out_valid && out_ready && clear) begin
        acc_idx.push_back(int'(out_index));
        acc_data.push_back(out_data);
        acc_cyc.push_back(cyc);
      end
      p_valid = out_valid; p_ready = out_ready; p_clear = clear;
      p_idx = out_index; p_data = out_data;

      // Advance the model through the coming rising edge.
      if (!clear) begin
        m_q.delete();
        m_busy = 0; m_valid = 0; m_done = 0; m_sel = '0; m_idx = '0;
        m_data = '0; m_csum = '0; m_wait = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1;
          if (count == 0) begin
            m_done = 1;
          end else begin
            for (int k = 0; k < int'(count); k++) m_q.push_back((int'(first_sel) + k) % NR);
            m_sel = first_sel; m_wait = S; m_csum = '0;
          end
        end
      end else if (m_done) begin
        m_busy = 0; m_done = 0;
      end else if (m_valid) begin
        if (out_ready) begin
          m_csum = m_csum + m_data;
          void'(m_q.pop_front());
          m_valid = 0;
          if (m_q.size() == 0) m_done = 1;
          else begin m_sel = SW'(m_q[0]); m_wait = S; end
        end
      end else if (m_wait == 0) begin
        m_valid = 1; m_idx = m_sel; m_data = reg_val(int'(m_sel));
      end else begin
        m_wait--;
      end
    end
  end

  int            hs0_cyc[$], done0_cnt = 0;
  logic [DW-1:0] hs0_data[$];
  always @(negedge clock) begin
    if (v0 && ready0 && clear) begin
      hs0_cyc.push_back(cyc);
      hs0_data.push_back(data0);
    end
    if (done0) done0_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (m_busy && n < 600) begin tick(); n++; end
    if (m_busy) begin
      errors++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
    end
  endtask

  task automatic run_window(input string name, input int fs, input int cnt,
                            input int stall_idx, input int stall_len, input int hold_sel);
    int stalled = 0, n = 0, base;
    bit injected = 0;
    acc_idx.delete(); acc_data.delete(); acc_cyc.delete();
    base = done_cnt;
    first_sel = SW'(fs); count = (SW+1)'(cnt); start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    while (m_busy && n < 600) begin
      if (m_valid && int'(m_idx) == stall_idx && stalled < stall_len) begin
        out_ready = 1'b0; stalled++;
      end else begin
        out_ready = 1'b1;
      end
      if (hold_sel >= 0 && !injected && m_valid) begin
        start = 1'b1; first_sel = SW'(hold_sel); injected = 1;
      end else begin
        start = 1'b0;
      end
      tick(); n++;
    end
    start = 1'b0; out_ready = 1'b1;
    if (m_busy) begin
      errors++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
    end
    chk({name, "_done_pulses"}, DW'(done_cnt - base), 32'd1);
    chk({name, "_words"}, DW'(acc_idx.size()), DW'(cnt));
  endtask

  initial begin
    int base, n;
    clear = 1'b0;
    tick(); tick();
    chk_en = 1;
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_index", DW'(out_index), 32'h0);
    chk("rst_select", DW'(sel), 32'h0);
    chk("rst_checksum", checksum, 32'h0);
    clear = 1'b1;
    tick();

    // Latency: valid two edges after the start edge.
    first_sel = 4'd5; count = 5'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("lat_e0_valid", DW'(out_valid), 32'd0);
    tick();
    chk("lat_e1_valid", DW'(out_valid), 32'd0);
    tick();
    chk("lat_e2_valid", DW'(out_valid), 32'd1);
    chk("lat_e2_data", out_data, 32'h55);
    chk("lat_e2_index", DW'(out_index), 32'd5);
    wait_idle("lat");

    // Case 1: full sweep.
    run_window("sweep", 0, 16, -1, 0, -1);
    for (int k = 0; k < acc_idx.size(); k++) begin
      chk("sweep_index", DW'(acc_idx[k]), DW'(k));
      if (k > 0) chk("sweep_spacing", DW'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);
    end
    if (acc_data.size() == 16) begin
      chk("sweep_data5", acc_data[5], 32'h55);
      chk("sweep_data15", acc_data[15], 32'hFF);
    end
    chk("sweep_checksum", checksum, CSUM_EN ? 32'h7F8 : 32'h0);
    chk("sweep_sel_hold", DW'(sel), 32'd15);

    // Case 2: wrap-around.
    run_window("wrap", 14, 4, -1, 0, -1);
    if (acc_idx.size() == 4) begin
      chk("wrap_idx0", DW'(acc_idx[0]), 32'd14);
      chk("wrap_idx1", DW'(acc_idx[1]), 32'd15);
      chk("wrap_idx2", DW'(acc_idx[2]), 32'd0);
      chk("wrap_idx3", DW'(acc_idx[3]), 32'd1);
      chk("wrap_data0", acc_data[0], 32'hEE);
      chk("wrap_data2", acc_data[2], 32'h00);
      chk("wrap_data3", acc_data[3], 32'h11);
    end
    chk("wrap_sel_hold", DW'(sel), 32'd1);

    // Case 3: backpressure on word 2.
    run_window("stall", 0, 5, 2, 5, -1);
    for (int k = 0; k < acc_idx.size(); k++) chk("stall_index", DW'(acc_idx[k]), DW'(k));

    // Case 4: empty window.
    base = done_cnt;
    count = 5'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("empty_busy", DW'(busy), 32'd1);
    chk("empty_done", DW'(done), 32'd1);
    tick();
    chk("empty_busy_after", DW'(busy), 32'd0);
    tick();
    chk("empty_done_count", DW'(done_cnt - base), 32'd1);

    // Case 5: reset in the second settle cycle of word 3.
    base = done_cnt;
    first_sel = 4'd0; count = 5'd8; start = 1'b1;
    tick(); start = 1'b0;
    n = 0;
    while (!(m_busy && !m_valid && !m_done && m_sel == 4'd3 && m_wait == 0) && n < 100) begin
      tick(); n++;
    end
    chk("abort_reached", DW'(sel), 32'd3);
    clear = 1'b0;
    tick(); clear = 1'b1;
    chk("abort_busy", DW'(busy), 32'd0);
    chk("abort_valid", DW'(out_valid), 32'd0);
    chk("abort_select", DW'(sel), 32'd0);
    tick(); tick();
    chk("abort_no_done", DW'(done_cnt - base), 32'd0);
    run_window("restart", 3, 3, -1, 0, -1);
    if (acc_idx.size() == 3) chk("restart_idx2", DW'(acc_idx[2]), 32'd5);

    // Case 6: start during HOLD is ignored.
    run_window("ignore", 0, 4, -1, 0, 9);
    if (acc_idx.size() == 4) chk("ignore_idx3", DW'(acc_idx[3]), 32'd3);
    tick();
    chk("ignore_idle", DW'(busy), 32'd0);

    // Zero-settle variant: one word every two cycles.
    first_sel = 4'd0; count = 5'd16; start0 = 1'b1;
    tick(); start0 = 1'b0;
    n = 0;
    while ((busy0 || hs0_cyc.size() < 16) && n < 200) begin tick(); n++; end
    tick();
    chk("s0_words", DW'(hs0_cyc.size()), 32'd16);
    for (int k = 1; k < hs0_cyc.size(); k++) begin
      chk("s0_spacing", DW'(hs0_cyc[k] - hs0_cyc[k-1]), 32'd2);
      chk("s0_data", hs0_data[k], reg_val(k));
    end
    chk("s0_done", DW'(done0_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
